nz_pair_encoder: RTL and testbench

//  Producer side of the reduction mux's sel/data interface in the unstructured-sparsity path.

---
 rtl/nz_pair_encoder_pkg.sv | 11 +
 rtl/nz_pair_encoder_if.sv | 24 ++
 rtl/nz_pair_encoder_lowest2_find.sv | 32 +++
 rtl/nz_pair_encoder.sv | 81 ++++++++
 tb/tb_nz_pair_encoder.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/nz_pair_encoder_pkg.sv
// nz_pair_encoder_pkg: shared FSM states and sel-pair packing helpers for the sparsity path.
package nz_pair_encoder_pkg;
    typedef enum logic {ST_IDLE, ST_EMIT} state_t;
    // Pairs are packed {left, right}, matching the reduction mux sel layout.
    function automatic int sel_left_lsb(input int w);
        return w;
    endfunction
    function automatic int sel_right_lsb(input int w);
        return 0;
    endfunction
endpackage

// File: rtl/nz_pair_encoder_if.sv
// nz_pair_encoder_if: dense-group input stream and sel/data pair output stream.
interface nz_pair_encoder_if #(
    parameter int DW_DATA = 8,
    parameter int NUM_IN  = 4,
    parameter int SEL_IN  = 2
);
    logic [DW_DATA*NUM_IN-1:0] in_data;
    logic                      in_valid;
    logic                      in_ready;
    logic [DW_DATA*2-1:0]      out_data;
    logic [SEL_IN*2-1:0]       out_sel;
    logic [1:0]                out_mask;
    logic                      out_last;
    logic                      out_valid;
    logic                      out_ready;
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_mask, out_last, out_valid
    );
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_mask, out_last, out_valid
    );
endinterface

// File: rtl/nz_pair_encoder_lowest2_find.sv
// nz_lowest2_find: two-level priority encoder returning the lowest and next-lowest set bits.
module nz_lowest2_find #(
    parameter int NUM_IN = 4,
    parameter int SEL_IN = 2
) (
    input  logic [NUM_IN-1:0] mask,
    output logic              found_l,
    output logic [SEL_IN-1:0] l_idx,
    output logic              found_r,
    output logic [SEL_IN-1:0] r_idx
);
    logic [NUM_IN-1:0] rest;
    always_comb begin
        found_r = 1'b0;
        r_idx   = '0;
        found_l = 1'b0;
        l_idx   = '0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (mask[i]) begin
                found_r = 1'b1;
                r_idx   = SEL_IN'(i);
            end
        end
        rest = mask & ~(NUM_IN'(found_r) << r_idx);
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (rest[i]) begin
                found_l = 1'b1;
                l_idx   = SEL_IN'(i);
            end
        end
    end
endmodule

// File: rtl/nz_pair_encoder.sv
// nz_pair_encoder: emits the nonzero elements of a dense group two per beat with their lane indices.
module nz_pair_encoder
    import nz_pair_encoder_pkg::*;
#(
    parameter int DW_DATA = 8,
    parameter int NUM_IN  = 4,
    parameter int SEL_IN  = 2
) (
    input logic clk,
    input logic rst_n,
    nz_pair_encoder_if.slave bus
);
    if (SEL_IN != $clog2(NUM_IN)) begin : g_sel_check
        $error("SEL_IN must equal $clog2(NUM_IN)");
    end

    state_t                    state, nxt;
    logic [DW_DATA*NUM_IN-1:0] grp;
    logic [NUM_IN-1:0]         rem, nz, clr, rest;
    logic                      found_l, found_r, accept, fire, last, emit;
    logic [SEL_IN-1:0]         l_idx, r_idx, sel_l, sel_r;
    logic [DW_DATA-1:0]        dat_l, dat_r;

    nz_lowest2_find #(.NUM_IN(NUM_IN), .SEL_IN(SEL_IN)) u_find (
        .mask    (rem),
        .found_l (found_l),
        .l_idx   (l_idx),
        .found_r (found_r),
        .r_idx   (r_idx)
    );

    assign emit         = rst_n && state == ST_EMIT;
    assign bus.in_ready = rst_n && state == ST_IDLE;
    assign accept       = bus.in_valid && bus.in_ready;
    assign fire         = emit && bus.out_ready;
    assign clr          = (NUM_IN'(found_r) << r_idx) | (NUM_IN'(found_l) << l_idx);
    assign rest         = rem & ~clr;
    assign last         = rest == '0;

    always_comb begin
        nz = '0;
        for (int i = 0; i < NUM_IN; i++) nz[i] = bus.in_data[i*DW_DATA +: DW_DATA] != '0;
    end

    always_comb begin
        nxt = state;
        if (state == ST_IDLE) nxt = accept ? ST_EMIT : ST_IDLE;
        else nxt = (fire && last) ? ST_IDLE : ST_EMIT;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            grp   <= '0;
            rem   <= '0;
        end else begin
            state <= nxt;
            if (accept) begin
                grp <= bus.in_data;
                rem <= nz;
            end else if (fire) begin
                rem <= rest;
            end
        end
    end

    // Outputs depend only on registered state; everything is zeroed outside EMIT.
    always_comb begin
        sel_l = (emit && found_l) ? l_idx : '0;
        sel_r = (emit && found_r) ? r_idx : '0;
        dat_l = (emit && found_l) ? grp[l_idx*DW_DATA +: DW_DATA] : '0;
        dat_r = (emit && found_r) ? grp[r_idx*DW_DATA +: DW_DATA] : '0;
    end

    assign bus.out_valid = emit;
    assign bus.out_last  = emit && last;
    assign bus.out_mask  = emit ? {found_l, found_r} : 2'b00;
    assign bus.out_data  = {dat_l, dat_r};
    assign bus.out_sel[sel_left_lsb(SEL_IN) +: SEL_IN]  = sel_l;
    assign bus.out_sel[sel_right_lsb(SEL_IN) +: SEL_IN] = sel_r;
endmodule

// File: tb/tb_nz_pair_encoder.sv
// tb_nz_pair_encoder: scoreboard bench with a list-based reference model and a reduction-mux check.
module tb_nz_pair_encoder;
    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  sel;
        logic [1:0]  mask;
        logic        last;
    } beat_t;

    logic clk, rst_n;
    int   total = 0, bad = 0, rdy_mode = 0;
    beat_t       exp_q[$];
    logic [31:0] g_q[$];

    nz_pair_encoder_if #(.DW_DATA(8), .NUM_IN(4), .SEL_IN(2)) bus ();
    nz_pair_encoder #(.DW_DATA(8), .NUM_IN(4), .SEL_IN(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic logic [7:0] elem(input logic [31:0] g, input int i);
        return g[i*8 +: 8];
    endfunction

    function automatic logic [3:0] nz_of(input logic [31:0] g);
        logic [3:0] m = '0;
        for (int i = 0; i < 4; i++) m[i] = elem(g, i) != 0;
        return m;
    endfunction

    // Reference: list the nonzero lanes in order, then pair them up (right, left).
    task automatic model(input logic [31:0] g);
        int    idx[$];
        beat_t b;
        for (int i = 0; i < 4; i++) if (elem(g, i) != 0) idx.push_back(i);
        if (idx.size() == 0) exp_q.push_back('{data: 16'h0, sel: 4'h0, mask: 2'b00, last: 1'b1});
        for (int k = 0; k < idx.size(); k += 2) begin
            int r = idx[k];
            int l = (k + 1 < idx.size()) ? idx[k+1] : 0;
            b.mask = (k + 1 < idx.size()) ? 2'b11 : 2'b01;
            b.sel  = {2'(l), 2'(r)};
            b.data = {b.mask[1] ? elem(g, l) : 8'h00, elem(g, r)};
            b.last = (k + 2 >= idx.size());
            exp_q.push_back(b);
        end
        g_q.push_back(g);
    endtask

    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
        end
    end

    // Monitor: pops the scoreboard on every consumed beat, independent of the driver.
    initial begin
        beat_t      e, held, cur;
        logic       hold = 0, rdy_next = 0;
        logic [3:0] emitted = '0, nb;
        logic [7:0] rl, rr;
        forever begin
            @(negedge clk);
            cur = {bus.out_data, bus.out_sel, bus.out_mask, bus.out_last};
            if (!rst_n) begin
                hold = 0;
                rdy_next = 0;
                emitted = '0;
            end else begin
                if (rdy_next) chk("ready_after_last", 32'(bus.in_ready), 1);
                rdy_next = 0;
                if (hold) begin
                    chk("hold_valid", 32'(bus.out_valid), 1);
                    chk("hold_stable", 32'(cur), 32'(held));
                end
                hold = 0;
                if (bus.out_valid) chk("busy_in_ready", 32'(bus.in_ready), 0);
                else chk("idle_outputs_zero", 32'(cur), 0);
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0 || g_q.size() == 0) fail("unexpected_beat");
                    else begin
                        e = exp_q.pop_front();
                        chk("beat_data", 32'(bus.out_data), 32'(e.data));
                        chk("beat_sel", 32'(bus.out_sel), 32'(e.sel));
                        chk("beat_mask", 32'(bus.out_mask), 32'(e.mask));
                        chk("beat_last", 32'(bus.out_last), 32'(e.last));
                        rl = bus.out_mask[1] ? elem(g_q[0], int'(bus.out_sel[3:2])) : 8'h00;
                        rr = bus.out_mask[0] ? elem(g_q[0], int'(bus.out_sel[1:0])) : 8'h00;
                        chk("rmux_data", 32'(bus.out_data), 32'({rl, rr}));
                        nb = (bus.out_mask[1] ? 4'(1) << bus.out_sel[3:2] : 4'h0) |
                             (bus.out_mask[0] ? 4'(1) << bus.out_sel[1:0] : 4'h0);
                        chk("no_duplicate", 32'(emitted & nb), 0);
                        emitted |= nb;
                        if (bus.out_last) begin
                            chk("all_nz_emitted", 32'(emitted), 32'(nz_of(g_q[0])));
                            void'(g_q.pop_front());
                            emitted = '0;
                            rdy_next = 1;
                        end
                    end
                end else if (bus.out_valid) begin
                    hold = 1;
                    held = cur;
                end
            end
        end
    end

    task automatic send(input logic [31:0] g);
        int t = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = g;
        while (!bus.in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (bus.in_ready) model(g);
        else fail("accept_timeout");
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) fail("drain_timeout");
        @(negedge clk);
    endtask

    task automatic wait_valid();
        int t = 0;
        while (!bus.out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.out_valid) fail("valid_timeout");
    endtask

    initial begin
        logic [31:0] g;
        beat_t       cap;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(bus.in_ready), 1);
        chk("post_rst_out_valid", 32'(bus.out_valid), 0);

        send(32'h0007_0003); drain();
        send(32'h0403_0201); drain();
        send(32'h0900_0000); drain();
        send(32'h0000_0000); drain();
        send(32'hFF00_0080); drain();

        rdy_mode = 2;
        send(32'h0403_0201);
        wait_valid();
        cap = {bus.out_data, bus.out_sel, bus.out_mask, bus.out_last};
        repeat (3) begin
            @(negedge clk);
            chk("stall_stable", 32'({bus.out_data, bus.out_sel, bus.out_mask, bus.out_last}), 32'(cap));
            chk("stall_in_ready", 32'(bus.in_ready), 0);
        end
        rdy_mode = 0;
        drain();

        rdy_mode = 2;
        send(32'h0403_0201);
        wait_valid();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        g_q.delete();
        @(negedge clk);
        chk("midrst_out_valid", 32'(bus.out_valid), 0);
        chk("midrst_in_ready", 32'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rdy_mode = 0;
        @(negedge clk);
        chk("after_rst_out_valid", 32'(bus.out_valid), 0);
        chk("after_rst_in_ready", 32'(bus.in_ready), 1);
        repeat (4) begin
            @(negedge clk);
            chk("no_beat2", 32'(bus.out_valid), 0);
        end

        rdy_mode = 1;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++) g[i*8 +: 8] = $urandom_range(0, 1) ? 8'($urandom) : 8'h00;
            repeat ($urandom_range(0, 1)) @(negedge clk);
            send(g);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
